proc_boot_sequencer: RTL and testbench

Boot/reset sequencer between the top-level stimulus and the processor core (Proc). Accepts a boot request and a start address and holds the core in reset for a programmed number of cycles. It then presents the start PC with a one-cycle valid strobe, releases the core, and supervises the run: it counts cycles until the core signals halt or a watchdog limit expires. It replaces free-running delay-based reset release with a clocked, checkable sequence.

---
 rtl/proc_boot_sequencer_if.sv | 29 ++
 rtl/proc_boot_sequencer.sv | 104 ++++++++++
 tb/tb_proc_boot_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/proc_boot_sequencer_if.sv
// Boot sequencer bundle: stimulus-side requests in, core-side controls out.
// master drives boot/halt/abort; slave (the sequencer) drives core controls.
interface proc_boot_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    logic                boot_req;
    logic [PC_WIDTH-1:0] boot_pc;
    logic                proc_halt;
    logic                abort;
    logic                proc_hold;
    logic [PC_WIDTH-1:0] start_pc;
    logic                pc_valid;
    logic                busy;
    logic                done;
    logic                timeout;
    logic [31:0]         run_cycles;

    modport master (
        output boot_req, boot_pc, proc_halt, abort,
        input  proc_hold, start_pc, pc_valid, busy,
        input  done, timeout, run_cycles
    );

    modport slave (
        input  boot_req, boot_pc, proc_halt, abort,
        output proc_hold, start_pc, pc_valid, busy,
        output done, timeout, run_cycles
    );
endinterface

// File: rtl/proc_boot_sequencer.sv
// Clocked boot sequencer: holds the core in reset, launches the start PC,
// then supervises the run until halt or watchdog expiry.
module proc_boot_sequencer #(
    parameter int                   HOLD_CYCLES = 16,
    parameter int                   WDOG_CYCLES = 10000,
    parameter int                   PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]  DEFAULT_PC  = '0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    proc_boot_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [31:0]    WDOG_LIM  = 32'(WDOG_CYCLES);

    state_t              state_q, state_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [PC_WIDTH-1:0] start_pc_q, start_pc_d;
    logic [31:0]         run_q, run_d;
    logic [31:0]         run_inc;
    logic                proc_hold_q;
    logic                pc_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                timeout_q;

    assign run_inc = (run_q == 32'hFFFF_FFFF) ? run_q : run_q + 32'd1;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        start_pc_d = start_pc_q;
        run_d      = run_q;
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (bus.boot_req) begin
                        state_d    = S_HOLD;
                        start_pc_d = bus.boot_pc;
                        run_d      = '0;
                        hold_cnt_d = '0;
                    end
                end
                S_HOLD: begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                    if (hold_cnt_q == HOLD_LAST) state_d = S_LAUNCH;
                end
                S_LAUNCH: state_d = S_RUN;
                S_RUN: begin
                    // The halt cycle is counted; halt beats the watchdog.
                    run_d = run_inc;
                    if (bus.proc_halt)           state_d = S_DONE;
                    else if (run_inc >= WDOG_LIM) state_d = S_TIMEOUT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            start_pc_q  <= DEFAULT_PC;
            run_q       <= '0;
            proc_hold_q <= 1'b1;
            pc_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            start_pc_q  <= start_pc_d;
            run_q       <= run_d;
            proc_hold_q <= (state_d != S_RUN);
            pc_valid_q  <= (state_d == S_LAUNCH);
            busy_q      <= (state_d == S_HOLD) || (state_d == S_LAUNCH) ||
                           (state_d == S_RUN);
            done_q      <= (state_d == S_DONE);
            timeout_q   <= (state_d == S_TIMEOUT);
        end
    end

    assign bus.proc_hold  = proc_hold_q;
    assign bus.start_pc   = start_pc_q;
    assign bus.pc_valid   = pc_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.run_cycles = run_q;
endmodule

// File: tb/tb_proc_boot_sequencer.sv
// Bench for proc_boot_sequencer: directed boots plus random boots checked
// against a timeline model derived from hold/launch/run durations.
module tb_proc_boot_sequencer;
    localparam int HOLD = 16;
    localparam int WDOG = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    proc_boot_sequencer_if #(.PC_WIDTH(32)) bif ();

    proc_boot_sequencer #(
        .HOLD_CYCLES (HOLD),
        .WDOG_CYCLES (WDOG),
        .PC_WIDTH    (32),
        .DEFAULT_PC  (32'h0)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bif)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rest_outs(input string tag, input bit e_done,
                             input bit e_to, input logic [31:0] e_pc,
                             input logic [31:0] e_run);
        chk({tag, ".hold"},    bif.proc_hold, 1);
        chk({tag, ".valid"},   bif.pc_valid, 0);
        chk({tag, ".busy"},    bif.busy, 0);
        chk({tag, ".done"},    bif.done, e_done);
        chk({tag, ".timeout"}, bif.timeout, e_to);
        chk({tag, ".pc"},      bif.start_pc, e_pc);
        chk({tag, ".run"},     bif.run_cycles, e_run);
    endtask

    // Model: after acceptance, intervals 0..HOLD-1 are hold, HOLD is launch,
    // run index r=k-HOLD (1-based) follows until halt or watchdog.
    task automatic boot(input logic [31:0] pc, input int halt_at,
                        input int abort_k, input bit noisy);
        int  r_end;
        bit  ends_done;
        int  r;
        bit  in_run;
        ends_done = (halt_at >= 1) && (halt_at <= WDOG);
        r_end     = ends_done ? halt_at : WDOG;
        bif.boot_req  = 1'b1;
        bif.boot_pc   = pc;
        bif.abort     = 1'b0;
        bif.proc_halt = 1'b0;
        step();
        for (int k = 0; k <= HOLD + r_end; k++) begin
            r      = k - HOLD;
            in_run = (k > HOLD);
            bif.boot_req  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bif.boot_pc   = noisy ? $urandom : pc;
            bif.abort     = (k == abort_k);
            bif.proc_halt = in_run ? (r == halt_at)
                                   : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
            chk("seq.hold",    bif.proc_hold, !in_run);
            chk("seq.valid",   bif.pc_valid, k == HOLD);
            chk("seq.busy",    bif.busy, 1);
            chk("seq.done",    bif.done, 0);
            chk("seq.timeout", bif.timeout, 0);
            chk("seq.pc",      bif.start_pc, pc);
            chk("seq.run",     bif.run_cycles, in_run ? r - 1 : 0);
            step();
            if (k == abort_k) begin
                bif.abort     = 1'b0;
                bif.boot_req  = 1'b0;
                bif.proc_halt = 1'b0;
                rest_outs("abort", 0, 0, pc, in_run ? r - 1 : 0);
                return;
            end
        end
        bif.boot_req  = 1'b0;
        bif.proc_halt = 1'b0;
        rest_outs("end", ends_done, !ends_done, pc, r_end);
    endtask

    initial begin
        logic [31:0] pc;
        int          h;
        int          a;

        bif.boot_req  = 1'b1;
        bif.boot_pc   = 32'h1234;
        bif.proc_halt = 1'b0;
        bif.abort     = 1'b0;
        rst_n         = 1'b0;
        repeat (3) step();
        rest_outs("reset", 0, 0, 32'h0, 0);

        rst_n = 1'b1;
        step();
        chk("rel.busy", bif.busy, 1);
        chk("rel.pc",   bif.start_pc, 32'h1234);
        bif.boot_req = 1'b0;
        bif.abort    = 1'b1;
        step();
        bif.abort = 1'b0;
        rest_outs("rel.abort", 0, 0, 32'h1234, 0);
        repeat (3) step();
        rest_outs("idle", 0, 0, 32'h1234, 0);

        boot(32'h0000_0400, 50, -1, 0);
        boot(32'h0000_1000, 0, -1, 0);
        boot(32'h0000_2000, WDOG, -1, 0);
        boot(32'h0000_0800, 7, -1, 1);

        bif.abort = 1'b1;
        bif.boot_req = 1'b1;
        step();
        bif.abort = 1'b0;
        bif.boot_req = 1'b0;
        rest_outs("done.abort", 0, 0, 32'h0800, 7);

        boot(32'h0000_0500, 30, 4, 1);
        boot(32'h0000_0600, 0, HOLD + 10, 0);

        for (int i = 0; i < 12; i++) begin
            pc = $urandom;
            h  = $urandom_range(0, WDOG + 10);
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, HOLD + WDOG) : -1;
            boot(pc, h, a, 1);
        end

        bif.boot_req = 1'b1;
        bif.boot_pc  = 32'hCAFE_0000;
        step();
        bif.boot_req = 1'b0;
        repeat (HOLD + 5) step();
        chk("mid.hold", bif.proc_hold, 0);
        rst_n = 1'b0;
        step();
        rest_outs("mid.reset", 0, 0, 32'h0, 0);
        rst_n = 1'b1;
        step();
        rest_outs("post", 0, 0, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
